// File: rtl/multi_timer_if.sv
// CPU MMIO bus as seen by the multi-channel timer: one chip-select,
// read/write strobes, {channel, reg} address, 8-bit data in each direction.
interface multi_timer_if #(
  parameter int AW = 3
) ();
  logic          cs_n;
  logic          re;
  logic          we;
  logic [AW-1:0] addr;
  logic [7:0]    dIn;
  logic [7:0]    dOut;

  modport master (output cs_n, re, we, addr, dIn, input dOut);
  modport slave  (input cs_n, re, we, addr, dIn, output dOut);
endinterface

// File: rtl/multi_timer.sv
// NUM_CH independent prescaled down-counters with reload, periodic/one-shot
// mode, interrupt mask and pending flag, behind one MMIO chip-select.
// Drives per-channel raw pending flags and one combined active-low interrupt.
module multi_timer #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 7,
  parameter int DIV_W  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_en,
  multi_timer_if.slave      bus,
  input  logic [NUM_CH-1:0] irq_ack,
  output logic [NUM_CH-1:0] irq_pend,
  output logic              irq_n
);

  // Address is {channel, reg[1:0]}; for a single channel only reg remains.
  localparam int AW = $clog2(NUM_CH) + 2;

  typedef struct packed {
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] reload;
    logic [DIV_W-1:0] div;
    logic             en;
    logic             oneshot;
    logic             mask;
    logic             pend;
  } ch_t;

  localparam ch_t CH_RST = '{
    counter: '0, reload: '0, div: '1,
    en: 1'b0, oneshot: 1'b0, mask: 1'b0, pend: 1'b0
  };

  typedef enum logic [1:0] {
    REG_CNT  = 2'd0,
    REG_CTRL = 2'd1,
    REG_STAT = 2'd2,
    REG_RSVD = 2'd3
  } reg_e;

  ch_t             ch_q [NUM_CH];
  ch_t             ch_d [NUM_CH];
  logic [AW-1:0]   ch_idx;
  reg_e            reg_sel;
  logic            wr_en;
  logic            rd_en;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] uf;
  logic            unused_dIn;

  assign ch_idx     = bus.addr >> 2;
  assign reg_sel    = reg_e'(bus.addr[1:0]);
  assign wr_en      = ~bus.cs_n & bus.we & clk_en;
  assign rd_en      = ~bus.cs_n & bus.re;
  assign unused_dIn = ^bus.dIn;

  // Next-state for every channel: prescaler, counter/underflow, then bus writes.
  // NOTE: every field starts from its current value so no path leaves a
  // signal unassigned, which keeps this block free of inferred latches.
  always_comb begin
    tick = '0;
    uf   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_d[c] = ch_q[c];
      tick[c] = clk_en & ch_q[c].en & (ch_q[c].div == '0);
      uf[c]   = tick[c] & (ch_q[c].counter == '0);

      if (clk_en && ch_q[c].en)
        ch_d[c].div = ch_q[c].div - DIV_W'(1);

      if (tick[c]) begin
        if (uf[c]) begin
          // Reads the registered reload, so a same-cycle reload write
          // only affects the following period.
          ch_d[c].counter = ch_q[c].reload;
          ch_d[c].pend    = 1'b1;
          if (ch_q[c].oneshot)
            ch_d[c].en = 1'b0;
        end else begin
          ch_d[c].counter = ch_q[c].counter - CNT_W'(1);
        end
      end

      if (wr_en && ch_idx == AW'(c)) begin
        case (reg_sel)
          REG_CNT: ch_d[c].reload = bus.dIn[CNT_W-1:0];
          REG_CTRL: begin
            if (bus.dIn[0]) begin
              // Start only from idle; a start while running is not a restart.
              if (!ch_q[c].en) begin
                ch_d[c].counter = ch_q[c].reload;
                ch_d[c].div     = '1;
                ch_d[c].en      = 1'b1;
              end
            end else begin
              ch_d[c].en = 1'b0;
            end
            ch_d[c].oneshot = bus.dIn[1];
            ch_d[c].mask    = bus.dIn[2];
          end
          REG_STAT: if (bus.dIn[0] && !uf[c]) ch_d[c].pend = 1'b0;
          default: ;
        endcase
      end

      // Underflow setting pend wins over any same-cycle clear.
      if (clk_en && irq_ack[c] && !uf[c])
        ch_d[c].pend = 1'b0;
    end
  end

  // Channel state register.
  // NOTE: state flops use non-blocking assignments; the comb block above uses
  // blocking ones. The channel array is a handful of flops, so it is reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++)
        ch_q[c] <= CH_RST;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        ch_q[c] <= ch_d[c];
    end
  end

  // Read mux: combinational, zero when not selected or channel out of range.
  always_comb begin
    bus.dOut = '0;
    if (rd_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_idx == AW'(c)) begin
          case (reg_sel)
            REG_CNT:  bus.dOut = 8'(ch_q[c].counter);
            REG_CTRL: bus.dOut = {5'b0, ch_q[c].mask, ch_q[c].oneshot, ch_q[c].en};
            REG_STAT: bus.dOut = {7'b0, ch_q[c].pend};
            default:  bus.dOut = '0;
          endcase
        end
      end
    end
  end

  // Interrupt outputs straight from flops: raw pend and masked OR.
  always_comb begin
    irq_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      irq_pend[c] = ch_q[c].pend;
      if (ch_q[c].pend && !ch_q[c].mask)
        irq_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: a register-access vector table after reset,
// then hand-written timing sequences for periodic, one-shot, masking,
// collisions, stalls, invalid channel and mid-count reset.
module tb_multi_timer;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 7;
  localparam int DIV_W  = 2;
  localparam int AW     = $clog2(NUM_CH) + 2;

  logic              clk;
  logic              reset_n;
  logic              clk_en;
  logic [NUM_CH-1:0] irq_ack;
  logic [NUM_CH-1:0] irq_pend;
  logic              irq_n;

  multi_timer_if #(.AW(AW)) bus ();

  multi_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_en   (clk_en),
    .bus      (bus),
    .irq_ack  (irq_ack),
    .irq_pend (irq_pend),
    .irq_n    (irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit         is_wr;
    int         ch;
    int         rg;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int rg, input logic [7:0] data);
    bus.cs_n = 1'b0;
    bus.we   = 1'b1;
    bus.addr = AW'((ch << 2) | rg);
    bus.dIn  = data;
    @(posedge clk);
    #1;
    bus.cs_n = 1'b1;
    bus.we   = 1'b0;
  endtask

  task automatic rd(input int ch, input int rg, output logic [7:0] data);
    bus.cs_n = 1'b0;
    bus.re   = 1'b1;
    bus.addr = AW'((ch << 2) | rg);
    #1;
    data     = bus.dOut;
    bus.cs_n = 1'b1;
    bus.re   = 1'b0;
  endtask

  task automatic ack(input int ch);
    irq_ack = NUM_CH'(1) << ch;
    @(posedge clk);
    #1;
    irq_ack = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    #1;
  endtask

  logic [7:0] d;

  initial begin
    // {is_wr, ch, reg, write data, expected read-back}
    vecs[0]  = '{0, 0, 0, 8'h00, 8'h00};
    vecs[1]  = '{0, 0, 1, 8'h00, 8'h00};
    vecs[2]  = '{0, 0, 2, 8'h00, 8'h00};
    vecs[3]  = '{0, 0, 3, 8'h00, 8'h00};
    vecs[4]  = '{0, 1, 0, 8'h00, 8'h00};
    vecs[5]  = '{0, 1, 1, 8'h00, 8'h00};
    vecs[6]  = '{0, 1, 2, 8'h00, 8'h00};
    vecs[7]  = '{0, 1, 3, 8'h00, 8'h00};
    vecs[8]  = '{0, 2, 1, 8'h00, 8'h00};
    vecs[9]  = '{0, 3, 0, 8'h00, 8'h00};
    vecs[10] = '{1, 0, 0, 8'hFF, 8'h00};  // reload write, counter still 0
    vecs[11] = '{1, 0, 1, 8'h06, 8'h06};  // oneshot+mask, not started
    vecs[12] = '{1, 0, 1, 8'hFE, 8'h06};  // upper bits read 0
    vecs[13] = '{1, 0, 3, 8'hFF, 8'h00};  // reserved
    vecs[14] = '{1, 0, 2, 8'h01, 8'h00};  // W1C with nothing pending
    vecs[15] = '{1, 1, 1, 8'h04, 8'h04};
    vecs[16] = '{1, 0, 1, 8'h00, 8'h00};
    vecs[17] = '{1, 1, 1, 8'h00, 8'h00};

    reset_n  = 1'b0;
    clk_en   = 1'b1;
    irq_ack  = '0;
    bus.cs_n = 1'b1;
    bus.re   = 1'b0;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.dIn  = '0;
    step(2);
    reset_n = 1'b1;
    step(1);

    // Reset values
    check("rst_irq_n", 32'(irq_n), 32'd1);
    check("rst_irq_pend", 32'(irq_pend), 32'd0);
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].is_wr) wr(vecs[i].ch, vecs[i].rg, vecs[i].data);
      rd(vecs[i].ch, vecs[i].rg, d);
      check($sformatf("vec%0d_ch%0d_r%0d", i, vecs[i].ch, vecs[i].rg), 32'(d), 32'(vecs[i].exp));
    end

    // Periodic: reload 3, period 16 clk_en cycles
    do_reset();
    wr(0, 0, 8'd3);
    wr(0, 1, 8'h01);
    rd(0, 0, d); check("per_cnt_c0", 32'(d), 32'd3);
    step(3);  rd(0, 0, d); check("per_cnt_c3", 32'(d), 32'd3);
    step(1);  rd(0, 0, d); check("per_cnt_c4", 32'(d), 32'd2);
    step(4);  rd(0, 0, d); check("per_cnt_c8", 32'(d), 32'd1);
    step(4);  rd(0, 0, d); check("per_cnt_c12", 32'(d), 32'd0);
    step(3);
    check("per_pend_c15", 32'(irq_pend), 32'd0);
    check("per_irqn_c15", 32'(irq_n), 32'd1);
    step(1);
    check("per_pend_c16", 32'(irq_pend), 32'd1);
    check("per_irqn_c16", 32'(irq_n), 32'd0);
    rd(0, 0, d); check("per_cnt_c16", 32'(d), 32'd3);
    ack(0);
    check("per_ack_irqn", 32'(irq_n), 32'd1);
    check("per_ack_pend", 32'(irq_pend), 32'd0);
    step(14); check("per_pend_c31", 32'(irq_pend), 32'd0);
    step(1);  check("per_pend_c32", 32'(irq_pend), 32'd1);

    // One-shot on ch1: reload 1 -> underflow at 8, then stop
    do_reset();
    wr(1, 0, 8'd1);
    wr(1, 1, 8'h03);
    step(7);
    check("os_pend_c7", 32'(irq_pend), 32'd0);
    rd(1, 1, d); check("os_ctrl_c7", 32'(d), 32'h03);
    step(1);
    check("os_pend_c8", 32'(irq_pend), 32'b010);
    rd(1, 1, d); check("os_ctrl_c8", 32'(d), 32'h02);
    rd(1, 0, d); check("os_cnt_c8", 32'(d), 32'd1);
    ack(1);
    step(20);
    check("os_no_repend", 32'(irq_pend), 32'd0);
    rd(1, 0, d); check("os_cnt_hold", 32'(d), 32'd1);

    // Mask and W1C: reload 0 underflows every 4 cycles
    do_reset();
    wr(0, 0, 8'd0);
    wr(0, 1, 8'h05);
    step(4);
    check("msk_pend_c4", 32'(irq_pend), 32'd1);
    check("msk_irqn_c4", 32'(irq_n), 32'd1);
    wr(0, 1, 8'h01);
    check("unmsk_irqn", 32'(irq_n), 32'd0);
    wr(0, 2, 8'h01);
    check("w1c_pend", 32'(irq_pend), 32'd0);
    check("w1c_irqn", 32'(irq_n), 32'd1);
    rd(0, 2, d); check("w1c_stat", 32'(d), 32'd0);
    step(2);
    check("msk_pend_c8", 32'(irq_pend), 32'd1);

    // Collisions: ack on underflow; reload write on underflow
    do_reset();
    wr(0, 0, 8'd3);
    wr(0, 1, 8'h01);
    step(15);
    ack(0);
    check("col_ack_pend", 32'(irq_pend), 32'd1);
    check("col_ack_irqn", 32'(irq_n), 32'd0);
    ack(0);
    check("col_ack_clr", 32'(irq_pend), 32'd0);
    step(14);
    wr(0, 0, 8'd5);
    rd(0, 0, d); check("col_rld_old", 32'(d), 32'd3);
    check("col_rld_pend", 32'(irq_pend), 32'd1);
    step(16);
    rd(0, 0, d); check("col_rld_new_c48", 32'(d), 32'd5);
    ack(0);
    step(22);
    check("col_pend_c71", 32'(irq_pend), 32'd0);
    rd(0, 0, d); check("col_cnt_c71", 32'(d), 32'd0);
    step(1);
    check("col_pend_c72", 32'(irq_pend), 32'd1);
    rd(0, 0, d); check("col_cnt_c72", 32'(d), 32'd5);

    // Restart write while running must not restart
    do_reset();
    wr(0, 0, 8'd3);
    wr(0, 1, 8'h01);
    step(5);
    wr(0, 1, 8'h01);
    rd(0, 0, d); check("rst_cnt_c6", 32'(d), 32'd2);
    step(9);  check("rs_pend_c15", 32'(irq_pend), 32'd0);
    step(1);  check("rs_pend_c16", 32'(irq_pend), 32'd1);

    // clk_en stall: counter, prescaler and writes frozen
    ack(0);
    clk_en = 1'b0;
    wr(0, 1, 8'h00);
    step(9);
    rd(0, 0, d); check("stall_cnt", 32'(d), 32'd3);
    rd(0, 1, d); check("stall_ctrl", 32'(d), 32'h01);
    clk_en = 1'b1;
    step(14); check("stall_pend_c31", 32'(irq_pend), 32'd0);
    step(1);  check("stall_pend_c32", 32'(irq_pend), 32'd1);

    // Out-of-range channel index
    wr(3, 1, 8'h01);
    wr(3, 0, 8'h11);
    rd(3, 1, d); check("bad_ch_ctrl", 32'(d), 32'd0);
    rd(3, 0, d); check("bad_ch_cnt", 32'(d), 32'd0);
    rd(0, 0, d); check("bad_ch_ch0_cnt", 32'(d), 32'd3);
    rd(1, 1, d); check("bad_ch_ch1_ctrl", 32'(d), 32'd0);

    // Reset mid-count: immediate, and stays idle afterwards
    check("pre_rst_irqn", 32'(irq_n), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_irqn", 32'(irq_n), 32'd1);
    check("mid_rst_pend", 32'(irq_pend), 32'd0);
    rd(0, 0, d); check("mid_rst_cnt", 32'(d), 32'd0);
    reset_n = 1'b1;
    step(8);
    rd(0, 1, d); check("post_rst_ctrl", 32'(d), 32'd0);
    rd(0, 0, d); check("post_rst_cnt", 32'(d), 32'd0);
    check("post_rst_pend", 32'(irq_pend), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised multi-channel successor to the single HuC6280 interval timer.
- Provides NUM_CH independent down-counters, each with its own prescaler, reload register, periodic/one-shot mode, interrupt mask and pending flag.
- Sits on the CPU MMIO bus behind one chip-select and drives a single combined active-low interrupt line plus per-channel pending outputs.

Parameters:
- NUM_CH, 2, number of timer channels (1..8)
- CNT_W, 7, counter/reload width in bits (1..8)
- DIV_W, 10, prescaler width; one tick every 2^DIV_W clk_en cycles

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clk_en  in  1  clock enable; all state updates occur only when high
- cs_n  in  1  chip select, active low
- re  in  1  read strobe
- we  in  1  write strobe
- addr  in  $clog2(NUM_CH)+2 (min 2)  {channel, reg[1:0]}
- dIn  in  8  write data
- dOut  out  8  read data
- irq_ack  in  NUM_CH  per-channel interrupt acknowledge
- irq_pend  out  NUM_CH  per-channel pending flags (raw, unmasked)
- irq_n  out  1  combined interrupt, active low

Behaviour:
- Reset (async, reset_n=0): per channel counter=0, reload=0, en=0, oneshot=0, mask=0, pend=0, div=all-ones. irq_pend=0, irq_n=1.
- Register map per channel (reg field):
  - 0: write reload<=dIn[CNT_W-1:0]; read counter (zero-extended)
  - 1: control, R/W; bit0 en, bit1 oneshot, bit2 mask (1=masked); other bits read 0
  - 2: status; read bit0=pend; write 1 to bit0 clears pend (W1C)
  - 3: reserved; reads 0, writes ignored
- Channel indices >= NUM_CH: reads 0, writes ignored.
- Read: dOut is combinational, valid when ~cs_n & re, else 0. No read side effects.
- Writes take effect when ~cs_n & we & clk_en.
- Start: control write with bit0=1 while en=0 -> counter<=reload, div<=all-ones, en<=1.
  - Control write with bit0=1 while en=1 updates oneshot/mask only; no restart.
- Stop: control write with bit0=0 -> en<=0; counter and div hold.
- Prescaler: while en, div decrements modulo 2^DIV_W each clk_en. Tick = en & div==0.
- On tick:
  - counter!=0 -> counter-1
  - counter==0 -> underflow: counter<=reload, pend<=1; if oneshot, en<=0
- Timing:
  - First tick falls on the 2^DIV_W-th clk_en after the start cycle.
  - Underflow falls on the (reload+1)*2^DIV_W-th clk_en after start; period is (reload+1)*2^DIV_W clk_en cycles.
  - reload=0 underflows on every tick.
- Reload write while running: counter unaffected; the new value is used from the next underflow. If a reload write and an underflow occur in the same cycle, the counter loads the OLD reload value.
- Pend clear sources: irq_ack[ch] or W1C. Set by underflow wins over a same-cycle clear.
- Outputs:
  - irq_pend = pend (registered).
  - irq_n = ~|(pend & ~mask), combinational from flops; visible the edge after the underflow cycle.
  - Masking does not clear pend; unmasking with pend set asserts irq_n immediately.
- Channels are fully independent; simultaneous underflows on several channels set every corresponding pend.
- clk_en=0: all state frozen, including pend set/clear and register writes.
- Reset asserted mid-count: immediate return to reset values. Deassertion requires a fresh start write.

Test Plan:
- Reset values: DIV_W=2, NUM_CH=2; pulse reset_n low, then read all registers -> all 0; irq_n=1, irq_pend=0.
- Periodic run: ch0 reload=3, start; clk_en=1 -> pend set after clk_en cycle 16, irq_n=0; ack -> irq_n=1; next underflow 16 cycles later; counter reads 3,2,1,0,3.
- One-shot: ch1 oneshot=1, reload=1, start -> pend after 8 cycles, en reads 0, counter holds 1, no further pend.
- Mask and W1C: ch0 mask=1, run to underflow -> irq_pend[0]=1, irq_n=1; clear mask -> irq_n=0; write status 0x01 -> pend=0, irq_n=1.
- Collisions: irq_ack on the underflow cycle -> pend stays 1. Reload write (5) on the underflow cycle -> counter=old reload, and the following period uses 5.
- Misc: re-start write while running -> count uninterrupted. Stall clk_en low 10 cycles -> counter/div frozen. Write to ch index 2 -> no effect; read returns 0. reset_n low mid-count -> outputs immediately at reset values.
